// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DMEM_WIDTH = 16;
    localparam logic [DMEM_WIDTH-1:0] MMIO_ADDR = {DMEM_WIDTH{1'b1}};

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM: one-cycle registered read, write-first on the same address.
module dmem_array #(
    parameter int DEPTH = 256,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
            dout      <= din;
        end else begin
            dout      <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Wait-stated load/store responder in front of dmem_array.
// Optional memory-mapped output register at the all-ones address: define DMEM_MMIO_EN.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WIDTH       = DMEM_WIDTH,
    parameter int WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic [WIDTH-1:0] memaddr,
    input  logic [WIDTH-1:0] memdin,
    input  logic             memwen,
    output logic [WIDTH-1:0] memdout,
`ifdef DMEM_MMIO_EN
    output logic [WIDTH-1:0] ioout,
`endif
    output logic             memrdy,
    output logic             memerr
);

    localparam int               AW     = $clog2(DEPTH);
    localparam logic [3:0]       WS     = 4'(WAIT_STATES);
    localparam logic [WIDTH-1:0] MMIO_A = {WIDTH{1'b1}};

    state_t           state;
    logic [3:0]       cnt;
    logic [WIDTH-1:0] addr_q;
    logic [WIDTH-1:0] data_q;
    logic             wen_q;
    logic [WIDTH-1:0] hold_q;
    logic             ram_pend_q;
    logic             rdy_q;
    logic             err_q;
`ifdef DMEM_MMIO_EN
    logic [WIDTH-1:0] io_q;
`endif

    logic             access;
    logic [WIDTH-1:0] acc_addr;
    logic [WIDTH-1:0] acc_data;
    logic             acc_wen;
    logic             acc_io;
    logic             acc_oor;
    logic             ram_we;
    logic [WIDTH-1:0] ram_dout;

    // With zero wait states the access happens on the accepting edge, straight from the ports.
    always_comb begin
        access   = 1'b0;
        acc_addr = addr_q;
        acc_data = data_q;
        acc_wen  = wen_q;
        if (state == IDLE) begin
            access   = req && (WS == 4'd0);
            acc_addr = memaddr;
            acc_data = memdin;
            acc_wen  = memwen;
        end else if (state == BUSY) begin
            access   = (cnt == 4'd1);
        end
`ifdef DMEM_MMIO_EN
        acc_io   = (acc_addr == MMIO_A);
`else
        acc_io   = 1'b0;
`endif
        acc_oor  = ((acc_addr >> AW) != '0) && !acc_io;
        ram_we   = access && acc_wen && !acc_oor && !acc_io && !rst;
    end

    dmem_array #(
        .DEPTH(DEPTH),
        .WIDTH(WIDTH)
    ) u_array (
        .clk (clk),
        .we  (ram_we),
        .addr(acc_addr[AW-1:0]),
        .din (acc_data),
        .dout(ram_dout)
    );

    // RAM reads land in the array's output register; it is shown during DONE, then copied to hold_q.
    assign memdout = ram_pend_q ? ram_dout : hold_q;
    assign memrdy  = rdy_q;
    assign memerr  = err_q;
`ifdef DMEM_MMIO_EN
    assign ioout   = io_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            hold_q     <= '0;
            ram_pend_q <= 1'b0;
            rdy_q      <= 1'b0;
            err_q      <= 1'b0;
`ifdef DMEM_MMIO_EN
            io_q       <= '0;
`endif
        end else begin
            rdy_q <= 1'b0;
            err_q <= 1'b0;
            if (ram_pend_q) begin
                hold_q     <= ram_dout;
                ram_pend_q <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (req) begin
                        addr_q <= memaddr;
                        data_q <= memdin;
                        wen_q  <= memwen;
                        cnt    <= WS;
                        state  <= (WS == 4'd0) ? DONE : BUSY;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
            if (access) begin
                rdy_q <= 1'b1;
                err_q <= acc_oor;
                if (!acc_wen) begin
                    if (acc_io) begin
`ifdef DMEM_MMIO_EN
                        hold_q <= io_q;
`endif
                    end else if (acc_oor) begin
                        hold_q <= '0;
                    end else begin
                        ram_pend_q <= 1'b1;
                    end
                end
`ifdef DMEM_MMIO_EN
                if (acc_wen && acc_io) io_q <= acc_data;
`endif
            end
        end
    end

endmodule
